seg_rx: RTL and testbench

- Receiving end of the three-wire 7-segment serial link (ds, shclk, stclk) that feeds the 74HC595-style display chain.
- Oversamples the link on the system clock, rebuilds the 16-bit frame ({digit select[15:8], segment pattern[7:0]}), and decodes it back to a hex nibble per digit position.
- Used as a display-mirror/monitor in the FPGA and as the bench-side checker for the display driver.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg_edge_sync.sv | 42 ++++
 rtl/seg_rx.sv | 140 ++++++++++++++
 tb/tb_seg_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment serial display link.
// Holds the segment code table (the single source used by both the display
// driver and the receiver), default frame geometry and the decode helpers.
//   seg_decode(pat)  -> {hit, nibble}   pattern lookup in the code table
//   onehot_idx(sel)  -> {ok, idx}       one-hot check and bit position
package seg_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int NUM_DIGITS_DEF = 8;
    localparam int IDX_W          = 3;

    // Active-low segment patterns, dp on bit 0, indexed by hex nibble.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic logic [4:0] seg_decode(input logic [7:0] pat);
        logic [4:0] res;
        res = 5'h00;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_TABLE[i]) begin
                res = {1'b1, 4'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W:0] onehot_idx(input logic [NUM_DIGITS_DEF-1:0] sel);
        logic [IDX_W:0] res;
        int             cnt;
        res = {(IDX_W+1){1'b0}};
        cnt = 0;
        for (int i = 0; i < NUM_DIGITS_DEF; i++) begin
            if (sel[i]) begin
                cnt = cnt + 1;
                res[IDX_W-1:0] = IDX_W'(i);
            end else begin
                res = res;
            end
        end
        res[IDX_W] = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/seg_edge_sync.sv
// N-stage synchroniser for one asynchronous input plus a rising-edge pulse.
//   clk, rst_n : system clock, async active-low reset
//   d_in       : asynchronous input
//   sync_o     : synchronised level
//   rise_o     : one-cycle pulse when sync_o goes 0 -> 1
module seg_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the input down the synchroniser chain; remember last output.
    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/seg_rx.sv
// Receiver for the three-wire 7-segment serial link (ds, shclk, stclk).
// Oversamples the link on clk, rebuilds each frame {sel[15:8], pat[7:0]},
// flags malformed frames and mirrors the decoded nibble per digit position.
//   clk, rst_n          : system clock, async active-low reset
//   ds, shclk, stclk    : asynchronous serial link inputs
//   frame_data/frame_stb: last latched frame and its one-cycle update pulse
//   digits/digit_valid  : decoded nibble per position and its valid flag
//   len_err/sel_err/seg_err : one-cycle error pulses aligned with frame_stb
module seg_rx
    import seg_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ds,
    input  logic                    shclk,
    input  logic                    stclk,
    output logic [FRAME_BITS-1:0]   frame_data,
    output logic                    frame_stb,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    len_err,
    output logic                    sel_err,
    output logic                    seg_err
);

    localparam logic [4:0] FRAME_LEN = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX   = 5'd31;

    logic ds_sync_s, ds_rise_unused_s;
    logic shclk_sync_unused_s, shclk_rise_s;
    logic stclk_sync_unused_s, stclk_rise_s;

    seg_edge_sync #(.STAGES(SYNC_STAGES)) u_ds_sync (
        .clk(clk), .rst_n(rst_n), .d_in(ds),
        .sync_o(ds_sync_s), .rise_o(ds_rise_unused_s)
    );
    seg_edge_sync #(.STAGES(SYNC_STAGES)) u_shclk_sync (
        .clk(clk), .rst_n(rst_n), .d_in(shclk),
        .sync_o(shclk_sync_unused_s), .rise_o(shclk_rise_s)
    );
    seg_edge_sync #(.STAGES(SYNC_STAGES)) u_stclk_sync (
        .clk(clk), .rst_n(rst_n), .d_in(stclk),
        .sync_o(stclk_sync_unused_s), .rise_o(stclk_rise_s)
    );

    logic [FRAME_BITS-1:0]   sr_q, sr_d, sr_shift_s;
    logic [4:0]              bit_cnt_q, bit_cnt_d, cnt_shift_s;
    logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
    logic                    frame_stb_q, frame_stb_d;
    logic                    len_err_q, len_err_d;
    logic                    sel_err_q, sel_err_d;
    logic                    seg_err_q, seg_err_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic [4:0]              chk_dec_s, out_dec_s;
    logic [IDX_W:0]          chk_oh_s, out_oh_s;

    // Shift, count and latch. A same-cycle shift is applied before the latch
    // so the coincident bit belongs to the frame being latched.
    always_comb begin
        if (shclk_rise_s) begin
            sr_shift_s  = {ds_sync_s, sr_q[FRAME_BITS-1:1]};
            cnt_shift_s = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + 5'd1;
        end else begin
            sr_shift_s  = sr_q;
            cnt_shift_s = bit_cnt_q;
        end
        chk_dec_s = seg_decode(sr_shift_s[7:0]);
        chk_oh_s  = onehot_idx(sr_shift_s[FRAME_BITS-1 -: NUM_DIGITS]);
        sr_d      = sr_shift_s;
        if (stclk_rise_s) begin
            bit_cnt_d    = 5'd0;
            frame_data_d = sr_shift_s;
            frame_stb_d  = 1'b1;
            len_err_d    = (cnt_shift_s != FRAME_LEN);
            sel_err_d    = ~chk_oh_s[IDX_W];
            seg_err_d    = ~chk_dec_s[4];
        end else begin
            bit_cnt_d    = cnt_shift_s;
            frame_data_d = frame_data_q;
            frame_stb_d  = 1'b0;
            len_err_d    = 1'b0;
            sel_err_d    = 1'b0;
            seg_err_d    = 1'b0;
        end
    end

    // Decode the frame latched last cycle into its digit position if clean.
    always_comb begin
        out_dec_s     = seg_decode(frame_data_q[7:0]);
        out_oh_s      = onehot_idx(frame_data_q[FRAME_BITS-1 -: NUM_DIGITS]);
        digits_d      = digits_q;
        digit_valid_d = digit_valid_q;
        if (frame_stb_q && !(len_err_q || sel_err_q || seg_err_q)) begin
            digits_d[4*int'(out_oh_s[IDX_W-1:0]) +: 4] = out_dec_s[3:0];
            digit_valid_d[out_oh_s[IDX_W-1:0]]         = 1'b1;
        end else begin
            digits_d      = digits_q;
            digit_valid_d = digit_valid_q;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q          <= {FRAME_BITS{1'b0}};
            bit_cnt_q     <= 5'd0;
            frame_data_q  <= {FRAME_BITS{1'b0}};
            frame_stb_q   <= 1'b0;
            len_err_q     <= 1'b0;
            sel_err_q     <= 1'b0;
            seg_err_q     <= 1'b0;
            digits_q      <= {(4*NUM_DIGITS){1'b0}};
            digit_valid_q <= {NUM_DIGITS{1'b0}};
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_stb_q   <= frame_stb_d;
            len_err_q     <= len_err_d;
            sel_err_q     <= sel_err_d;
            seg_err_q     <= seg_err_d;
            digits_q      <= digits_d;
            digit_valid_q <= digit_valid_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_stb   = frame_stb_q;
    assign len_err     = len_err_q;
    assign sel_err     = sel_err_q;
    assign seg_err     = seg_err_q;
    assign digits      = digits_q;
    assign digit_valid = digit_valid_q;

endmodule

// File: tb/tb_seg_rx.sv
module tb_seg_rx;

    logic        clk;
    logic        rst_n;
    logic        ds;
    logic        shclk;
    logic        stclk;
    logic [15:0] frame_data;
    logic        frame_stb;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        len_err;
    logic        sel_err;
    logic        seg_err;

    seg_rx dut (
        .clk(clk), .rst_n(rst_n), .ds(ds), .shclk(shclk), .stclk(stclk),
        .frame_data(frame_data), .frame_stb(frame_stb),
        .digits(digits), .digit_valid(digit_valid),
        .len_err(len_err), .sel_err(sel_err), .seg_err(seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] frame;
        logic        len;
        logic        sel;
        logic        seg;
        logic [31:0] dig;
        logic [7:0]  val;
    } vec_t;

    vec_t tbl [7];

    // observation results of one latch
    int          stb_cnt;
    int          lat;
    logic        o_len, o_sel, o_seg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        ds = b;
        repeat (5) @(negedge clk);
        shclk = 1'b1;
        repeat (5) @(negedge clk);
        shclk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) shift_bit(bits[i]);
        repeat (5) @(negedge clk);
    endtask

    // Raise stclk (optionally together with shclk) and watch a bounded window.
    task automatic latch(input logic with_shift);
        @(negedge clk);
        if (with_shift) shclk = 1'b1;
        stclk = 1'b1;
        stb_cnt = 0; lat = 0; o_len = 1'b0; o_sel = 1'b0; o_seg = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (frame_stb) begin
                stb_cnt++;
                if (lat == 0) lat = c;
            end
            o_len = o_len | len_err;
            o_sel = o_sel | sel_err;
            o_seg = o_seg | seg_err;
        end
        stclk = 1'b0;
        shclk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] f, input logic l,
                             input logic s, input logic g, input logic [31:0] dg,
                             input logic [7:0] v);
        chk({tag, ".stb_cnt"}, 32'(stb_cnt), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        chk({tag, ".frame_data"}, {16'h0000, frame_data}, {16'h0000, f});
        chk({tag, ".len_err"}, {31'd0, o_len}, {31'd0, l});
        chk({tag, ".sel_err"}, {31'd0, o_sel}, {31'd0, s});
        chk({tag, ".seg_err"}, {31'd0, o_seg}, {31'd0, g});
        chk({tag, ".digits"}, digits, dg);
        chk({tag, ".digit_valid"}, {24'd0, digit_valid}, {24'd0, v});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".frame_data"}, {16'h0000, frame_data}, 32'h0);
        chk({tag, ".strobes"}, {28'd0, frame_stb, len_err, sel_err, seg_err}, 32'h0);
        chk({tag, ".digits"}, digits, 32'h0);
        chk({tag, ".digit_valid"}, {24'd0, digit_valid}, 32'h0);
    endtask

    logic [63:0] bits_v;

    initial begin
        tbl[0] = '{16'h0103, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'h01};
        tbl[1] = '{16'h2011, 1'b0, 1'b0, 1'b0, 32'h00A0_0000, 8'h21};
        tbl[2] = '{16'h04FF, 1'b0, 1'b0, 1'b1, 32'h00A0_0000, 8'h21};
        tbl[3] = '{16'h0325, 1'b0, 1'b1, 1'b0, 32'h00A0_0000, 8'h21};
        tbl[4] = '{16'h0861, 1'b0, 1'b0, 1'b0, 32'h00A0_E000, 8'h29};
        tbl[5] = '{16'h8009, 1'b0, 1'b0, 1'b0, 32'h90A0_E000, 8'hA9};
        tbl[6] = '{16'h0000, 1'b0, 1'b1, 1'b1, 32'h90A0_E000, 8'hA9};

        rst_n = 1'b0; ds = 1'b0; shclk = 1'b0; stclk = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            bits_v = {48'd0, tbl[i].frame};
            send_bits(bits_v, 16);
            latch(1'b0);
            chk_frame($sformatf("vec%0d", i), tbl[i].frame, tbl[i].len, tbl[i].sel,
                      tbl[i].seg, tbl[i].dig, tbl[i].val);
        end

        // short frame: 15 shifts
        bits_v = {48'd0, 16'h0125};
        send_bits(bits_v, 15);
        latch(1'b0);
        chk("short.len_err", {31'd0, o_len}, 32'd1);
        chk("short.digits", digits, 32'h90A0_E000);
        chk("short.digit_valid", {24'd0, digit_valid}, 32'h0000_00A9);

        // recovery with a clean frame
        send_bits(bits_v, 16);
        latch(1'b0);
        chk_frame("recover", 16'h0125, 1'b0, 1'b0, 1'b0, 32'h90A0_E002, 8'hA9);

        // 48 shifts: a wrapping counter would read 16 here
        bits_v = 64'd0;
        send_bits(bits_v, 48);
        latch(1'b0);
        chk("sat.len_err", {31'd0, o_len}, 32'd1);
        chk("sat.digits", digits, 32'h90A0_E002);

        bits_v = {48'd0, 16'h0103};
        send_bits(bits_v, 16);
        latch(1'b0);
        chk_frame("post_sat", 16'h0103, 1'b0, 1'b0, 1'b0, 32'h90A0_E000, 8'hA9);

        // coincident 16th shift and latch
        bits_v = {48'd0, 16'h4099};
        send_bits(bits_v, 15);
        ds = bits_v[15];
        repeat (5) @(negedge clk);
        latch(1'b1);
        chk_frame("coincident", 16'h4099, 1'b0, 1'b0, 1'b0, 32'h94A0_E000, 8'hE9);

        // reset in the middle of a frame
        bits_v = {48'd0, 16'h0261};
        send_bits(bits_v, 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bits_v = {48'd0, 16'h0103};
        send_bits(bits_v, 16);
        latch(1'b0);
        chk_frame("after_reset", 16'h0103, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
